ps2_keyboard_receiver: RTL and testbench

Receives scan-code frames from a PS/2 keyboard on the PS2_Clk/PS2_Dat lines and delivers each byte as Kb_Byte to the IO module's keyboard input path (IO = 2). Sits between the board PS/2 pins and the IO module, clocked by Fast_Clock. It synchronises and filters the asynchronous lines, deframes 11-bit frames, and checks parity, stop bit and timeout. Optionally it strips break/extended prefixes.

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_line_filter.sv | 56 +++++
 rtl/ps2_keyboard_receiver.sv | 231 +++++++++++++++++++++++
 tb/tb_ps2_keyboard_receiver.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0]  PS2_BREAK     = 8'hF0;
    localparam logic [7:0]  PS2_EXT       = 8'hE0;
    localparam int unsigned PS2_FRAME_LEN = 11;

    // Odd parity: the data byte together with the parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a stability filter for one PS/2 line.
// The filtered output only follows the line after it has held a new level
// for FILTER_LEN consecutive cycles. Reset reloads the idle-high level.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic line_o
);

    localparam int unsigned CNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             filt_q;
    logic             filt_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Stability counter: count while the synchronised line differs from the filtered level.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = {CNT_W{1'b0}};
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = sync2_q;
                cnt_d  = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Synchroniser and filter state registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign line_o = filt_q;

endmodule

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard receiver: filters the raw pins, deframes 11-bit frames,
// checks parity/stop/timeout and delivers scan-code bytes.
// Optional feature macro: PS2_BREAK_FILTER_EN strips E0/F0 prefixes and
// suppresses break codes so that only make codes are delivered.
module ps2_keyboard_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       Fast_Clock,
    input  logic       Reset_N,
    input  logic       PS2_Clk,
    input  logic       PS2_Dat,
    output logic [7:0] Kb_Byte,
    output logic       Kb_Valid,
    output logic       Kb_Ext,
    output logic       Parity_Error,
    output logic       Frame_Error,
    output logic       Busy
);

    localparam int unsigned DATA_BITS = PS2_FRAME_LEN - 3;
    localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);
    localparam int unsigned TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic clk_filt_s;
    logic dat_filt_s;
    logic strobe_s;

    ps2_state_e       state_q,    state_d;
    logic [2:0]       bit_cnt_q,  bit_cnt_d;
    logic [7:0]       shreg_q,    shreg_d;
    logic             par_q,      par_d;
    logic [TMO_W-1:0] tmo_q,      tmo_d;
    logic             clk_prev_q;
    logic [7:0]       kb_byte_q,  kb_byte_d;
    logic             kb_valid_q, kb_valid_d;
    logic             perr_q,     perr_d;
    logic             ferr_q,     ferr_d;
    logic             busy_q,     busy_d;
`ifdef PS2_BREAK_FILTER_EN
    logic             kb_ext_q,   kb_ext_d;
    logic             ext_pend_q, ext_pend_d;
    logic             brk_pend_q, brk_pend_d;
`endif

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk_i  (Fast_Clock),
        .rst_ni (Reset_N),
        .line_i (PS2_Clk),
        .line_o (clk_filt_s)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .clk_i  (Fast_Clock),
        .rst_ni (Reset_N),
        .line_i (PS2_Dat),
        .line_o (dat_filt_s)
    );

    // A falling edge of the filtered clock marks the moment to sample data.
    assign strobe_s = clk_prev_q & ~clk_filt_s;

    // Next-state logic: deframing FSM, timeout, frame checks and prefix handling.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        tmo_d      = {TMO_W{1'b0}};
        kb_byte_d  = kb_byte_q;
        kb_valid_d = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
        kb_ext_d   = kb_ext_q;
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
`endif

        if (strobe_s) begin
            tmo_d = {TMO_W{1'b0}};
        end else if (state_q != IDLE) begin
            tmo_d = tmo_q + TMO_W'(1);
        end else begin
            tmo_d = {TMO_W{1'b0}};
        end

        if ((state_q != IDLE) && !strobe_s && (tmo_q == TMO_LAST)) begin
            // No clock edge for too long: abandon the partial frame.
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            tmo_d     = {TMO_W{1'b0}};
            ferr_d    = 1'b1;
`ifdef PS2_BREAK_FILTER_EN
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (strobe_s && !dat_filt_s) begin
                        state_d   = SHIFT;
                        bit_cnt_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                SHIFT: begin
                    if (strobe_s) begin
                        shreg_d   = {dat_filt_s, shreg_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = PARITY;
                        end else begin
                            state_d = SHIFT;
                        end
                    end else begin
                        state_d = SHIFT;
                    end
                end
                PARITY: begin
                    if (strobe_s) begin
                        par_d   = dat_filt_s;
                        state_d = STOP;
                    end else begin
                        state_d = PARITY;
                    end
                end
                STOP: begin
                    if (strobe_s) begin
                        state_d = IDLE;
                        if (!dat_filt_s) begin
                            ferr_d = 1'b1;
`ifdef PS2_BREAK_FILTER_EN
                            ext_pend_d = 1'b0;
                            brk_pend_d = 1'b0;
`endif
                        end else if (!odd_parity_ok(shreg_q, par_q)) begin
                            perr_d = 1'b1;
`ifdef PS2_BREAK_FILTER_EN
                            ext_pend_d = 1'b0;
                            brk_pend_d = 1'b0;
`endif
                        end else begin
`ifdef PS2_BREAK_FILTER_EN
                            if (shreg_q == PS2_EXT) begin
                                ext_pend_d = 1'b1;
                            end else if (shreg_q == PS2_BREAK) begin
                                brk_pend_d = 1'b1;
                            end else if (brk_pend_q) begin
                                // Released key: drop the code and forget the prefixes.
                                brk_pend_d = 1'b0;
                                ext_pend_d = 1'b0;
                            end else begin
                                kb_byte_d  = shreg_q;
                                kb_valid_d = 1'b1;
                                kb_ext_d   = ext_pend_q;
                                ext_pend_d = 1'b0;
                            end
`else
                            kb_byte_d  = shreg_q;
                            kb_valid_d = 1'b1;
`endif
                        end
                    end else begin
                        state_d = STOP;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Fast_Clock) begin
        if (!Reset_N) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            shreg_q    <= 8'h00;
            par_q      <= 1'b0;
            tmo_q      <= {TMO_W{1'b0}};
            clk_prev_q <= 1'b1;
            kb_byte_q  <= 8'h00;
            kb_valid_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
            kb_ext_q   <= 1'b0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            clk_prev_q <= clk_filt_s;
            kb_byte_q  <= kb_byte_d;
            kb_valid_q <= kb_valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            busy_q     <= busy_d;
`ifdef PS2_BREAK_FILTER_EN
            kb_ext_q   <= kb_ext_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
`endif
        end
    end

    assign Kb_Byte      = kb_byte_q;
    assign Kb_Valid     = kb_valid_q;
    assign Parity_Error = perr_q;
    assign Frame_Error  = ferr_q;
    assign Busy         = busy_q;
`ifdef PS2_BREAK_FILTER_EN
    assign Kb_Ext       = kb_ext_q;
`else
    assign Kb_Ext       = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Scoreboard bench for ps2_keyboard_receiver: stimulus pushes expected
// events, a monitor pops and compares whenever the DUT pulses an output.
module tb_ps2_keyboard_receiver;

    localparam int FL   = 8;
    localparam int TMO  = 300;
    localparam int HALF = 20;

    localparam logic [1:0] EV_VALID = 2'd0;
    localparam logic [1:0] EV_PERR  = 2'd1;
    localparam logic [1:0] EV_FERR  = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] b;
        logic       ext;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] kb_byte;
    logic       kb_valid, kb_ext, par_err, frm_err, busy;

    ev_t        exp_q[$];
    int         tests = 0;
    int         fails = 0;
    logic [7:0] last_b = 8'h00;
    logic       last_ext = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
    logic       ext_p = 1'b0;
    logic       brk_p = 1'b0;
`endif

    always #5 clk = ~clk;

    ps2_keyboard_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
        .Fast_Clock   (clk),
        .Reset_N      (rst_n),
        .PS2_Clk      (ps2_clk),
        .PS2_Dat      (ps2_dat),
        .Kb_Byte      (kb_byte),
        .Kb_Valid     (kb_valid),
        .Kb_Ext       (kb_ext),
        .Parity_Error (par_err),
        .Frame_Error  (frm_err),
        .Busy         (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [7:0] b, input logic ext);
        ev_t e;
        e.kind = kind;
        e.b    = b;
        e.ext  = ext;
        exp_q.push_back(e);
    endtask

    task automatic clear_pending();
`ifdef PS2_BREAK_FILTER_EN
        ext_p = 1'b0;
        brk_p = 1'b0;
`endif
    endtask

    // Reference behaviour of one complete frame, from the byte-level rules.
    task automatic model_frame(input logic [7:0] d, input logic par_ok, input logic stop_ok);
        if (!stop_ok) begin
            push(EV_FERR, last_b, last_ext);
            clear_pending();
        end else if (!par_ok) begin
            push(EV_PERR, last_b, last_ext);
            clear_pending();
        end else begin
`ifdef PS2_BREAK_FILTER_EN
            if (d == 8'hE0) ext_p = 1'b1;
            else if (d == 8'hF0) brk_p = 1'b1;
            else if (brk_p) begin
                brk_p = 1'b0;
                ext_p = 1'b0;
            end else begin
                last_b = d;
                last_ext = ext_p;
                push(EV_VALID, d, ext_p);
                ext_p = 1'b0;
            end
`else
            last_b = d;
            push(EV_VALID, d, 1'b0);
`endif
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic flip, input logic stop);
        logic p;
        p = (~^d) ^ flip;
        return {stop, p, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] frame, input int from, input int to);
        for (int i = from; i <= to; i++) begin
            @(negedge clk);
            ps2_dat = frame[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop);
        model_frame(d, !flip, stop);
        send_bits(mk_frame(d, flip, stop), 0, 10);
        repeat (10) @(negedge clk);
    endtask

    // Monitor: compare every DUT output pulse against the head of the queue.
    always @(negedge clk) begin
        if (rst_n && (kb_valid || par_err || frm_err)) begin
            ev_t e;
            logic [1:0] kind_act;
            check("exclusive", 32'(kb_valid) + 32'(par_err) + 32'(frm_err), 32'd1);
            kind_act = kb_valid ? EV_VALID : (par_err ? EV_PERR : EV_FERR);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected: got event kind %0d byte %0h, expected none", kind_act, kb_byte);
            end else begin
                e = exp_q.pop_front();
                check("kind", 32'(kind_act), 32'(e.kind));
                check("kb_byte", 32'(kb_byte), 32'(e.b));
                check("kb_ext", 32'(kb_ext), 32'(e.ext));
            end
        end
    end

    initial begin
        logic [10:0] f;
        logic [7:0]  d;
        int          r;

        // Reset state.
        repeat (5) @(negedge clk);
        check("rst_byte", 32'(kb_byte), 32'h00);
        check("rst_valid", 32'(kb_valid), 32'd0);
        check("rst_ext", 32'(kb_ext), 32'd0);
        check("rst_perr", 32'(par_err), 32'd0);
        check("rst_ferr", 32'(frm_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Directed frames: good, parity error, stop error, good.
        send_frame(8'h1C, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b0);
        send_frame(8'h32, 1'b0, 1'b1);

        // Timeout after five bits, then a good frame.
        push(EV_FERR, last_b, last_ext);
        clear_pending();
        send_bits(mk_frame(8'h24, 1'b0, 1'b1), 0, 4);
        check("busy_mid", 32'(busy), 32'd1);
        repeat (TMO + 10) @(negedge clk);
        check("busy_tmo", 32'(busy), 32'd0);
        send_frame(8'h24, 1'b0, 1'b1);

        // Prefix sequence.
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);

        // Short glitch on the clock while it is high mid-frame.
        model_frame(8'h5A, 1'b1, 1'b1);
        f = mk_frame(8'h5A, 1'b0, 1'b1);
        send_bits(f, 0, 4);
        repeat (12) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        send_bits(f, 5, 10);
        repeat (10) @(negedge clk);

        // Randomized frames with occasional parity or stop errors.
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 7);
            d = 8'($urandom);
            send_frame(d, (r == 0), (r != 1));
        end

        // Reset during bit 4 of a frame.
        f = mk_frame(8'h66, 1'b0, 1'b1);
        send_bits(f, 0, 4);
        @(negedge clk);
        ps2_dat = f[5];
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check("mrst_byte", 32'(kb_byte), 32'h00);
        check("mrst_valid", 32'(kb_valid), 32'd0);
        check("mrst_ext", 32'(kb_ext), 32'd0);
        check("mrst_perr", 32'(par_err), 32'd0);
        check("mrst_ferr", 32'(frm_err), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        last_b = 8'h00;
        last_ext = 1'b0;
        clear_pending();
        ps2_dat = 1'b1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h4B, 1'b0, 1'b1);

        repeat (50) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
